// File: rtl/axi_sram_slv.sv
// AXI4 slave that terminates read/write bursts into a byte-writable on-chip SRAM.
// One transaction in flight at a time; FIXED/INCR bursts; DECERR/SLVERR on RRESP/BRESP.
module axi_sram_slv #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 64,
  parameter int unsigned   LOCKW     = 1,
  parameter int unsigned   AXILENW   = 8,
  parameter int unsigned   MEM_AW    = 12,
  parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  // read address
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  input  logic [AW-1:0]      s_axi_araddr,
  input  logic [3:0]         s_axi_arcache,
  input  logic [2:0]         s_axi_arprot,
  input  logic [LOCKW-1:0]   s_axi_arlock,
  input  logic [1:0]         s_axi_arburst,
  input  logic [AXILENW-1:0] s_axi_arlen,
  input  logic [2:0]         s_axi_arsize,
  // write address
  input  logic               s_axi_awvalid,
  output logic               s_axi_awready,
  input  logic [AW-1:0]      s_axi_awaddr,
  input  logic [3:0]         s_axi_awcache,
  input  logic [2:0]         s_axi_awprot,
  input  logic [LOCKW-1:0]   s_axi_awlock,
  input  logic [1:0]         s_axi_awburst,
  input  logic [AXILENW-1:0] s_axi_awlen,
  input  logic [2:0]         s_axi_awsize,
  // read data
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  output logic [DW-1:0]      s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rlast,
  // write data
  input  logic               s_axi_wvalid,
  output logic               s_axi_wready,
  input  logic [DW-1:0]      s_axi_wdata,
  input  logic [DW/8-1:0]    s_axi_wstrb,
  input  logic               s_axi_wlast,
  // write response
  output logic               s_axi_bvalid,
  input  logic               s_axi_bready,
  output logic [1:0]         s_axi_bresp
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned OFFW  = $clog2(NB);
  localparam int unsigned DEPTH = 2 ** MEM_AW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_WRESP} state_e;

  state_e               state_q, state_d;
  logic                 last_wr_q, last_wr_d;   // 1: last grant went to a write
  logic [MEM_AW-1:0]    idx_q, idx_d;
  logic [AXILENW-1:0]   len_q, len_d;
  logic [AXILENW-1:0]   cnt_q, cnt_d;
  logic                 inc_q, inc_d;
  logic [1:0]           err_q, err_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rlast_q, rlast_d;
  logic [1:0]           rresp_q, rresp_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [DW-1:0]        rdata_q;
  logic [DW-1:0]        mem_q [DEPTH];

  logic [AW-1:0]        ar_off_c, aw_off_c;
  logic [1:0]           ar_err_c, aw_err_c;
  logic                 pick_rd_c;
  logic [MEM_AW-1:0]    idx_nx_c;
  logic                 w_beat_last_c;
  logic [1:0]           w_err_c;
  logic                 rd_en_c, rd_zero_c, wr_en_c;
  logic [MEM_AW-1:0]    rd_idx_c;
  logic                 unused_c;

  // Address decode and per-transaction error classification
  assign ar_off_c = s_axi_araddr - BASE_ADDR;
  assign aw_off_c = s_axi_awaddr - BASE_ADDR;
  assign ar_err_c = (|ar_off_c[AW-1:MEM_AW+OFFW]) ? RESP_DECERR :
                    (s_axi_arburst[1] || s_axi_arsize != 3'(OFFW)) ? RESP_SLVERR : RESP_OKAY;
  assign aw_err_c = (|aw_off_c[AW-1:MEM_AW+OFFW]) ? RESP_DECERR :
                    (s_axi_awburst[1] || s_axi_awsize != 3'(OFFW)) ? RESP_SLVERR : RESP_OKAY;

  // Round-robin between AR and AW when both are pending
  assign pick_rd_c     = s_axi_arvalid & (~s_axi_awvalid | last_wr_q);
  assign idx_nx_c      = inc_q ? MEM_AW'(idx_q + 1'b1) : idx_q;
  assign w_beat_last_c = (cnt_q == len_q);
  assign w_err_c       = (s_axi_wlast != w_beat_last_c) ? RESP_SLVERR : err_q;

  assign unused_c = ^{s_axi_arcache, s_axi_arprot, s_axi_arlock, s_axi_awcache,
                      s_axi_awprot, s_axi_awlock, ar_off_c[OFFW-1:0], aw_off_c[OFFW-1:0]};

  // Next-state, handshake readies and SRAM access controls
  always_comb begin
    state_d       = state_q;
    last_wr_d     = last_wr_q;
    idx_d         = idx_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    inc_d         = inc_q;
    err_d         = err_q;
    rvalid_d      = rvalid_q;
    rlast_d       = rlast_q;
    rresp_d       = rresp_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    rd_en_c       = 1'b0;
    rd_idx_c      = idx_nx_c;
    rd_zero_c     = (err_q != RESP_OKAY);
    wr_en_c       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        s_axi_arready = ~rst & s_axi_arvalid & pick_rd_c;
        s_axi_awready = ~rst & s_axi_awvalid & ~pick_rd_c;
        if (s_axi_arready) begin
          state_d   = ST_RD;
          last_wr_d = 1'b0;
          idx_d     = ar_off_c[MEM_AW+OFFW-1:OFFW];
          len_d     = s_axi_arlen;
          cnt_d     = '0;
          inc_d     = (s_axi_arburst == BURST_INCR);
          err_d     = ar_err_c;
          rd_en_c   = 1'b1;
          rd_idx_c  = ar_off_c[MEM_AW+OFFW-1:OFFW];
          rd_zero_c = (ar_err_c != RESP_OKAY);
          rvalid_d  = 1'b1;
          rlast_d   = (s_axi_arlen == '0);
          rresp_d   = ar_err_c;
        end else if (s_axi_awready) begin
          state_d   = ST_WR;
          last_wr_d = 1'b1;
          idx_d     = aw_off_c[MEM_AW+OFFW-1:OFFW];
          len_d     = s_axi_awlen;
          cnt_d     = '0;
          inc_d     = (s_axi_awburst == BURST_INCR);
          err_d     = aw_err_c;
        end
      end
      ST_RD: begin
        if (s_axi_rready) begin
          if (cnt_q == len_q) begin
            state_d  = ST_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rresp_d  = RESP_OKAY;
          end else begin
            cnt_d   = AXILENW'(cnt_q + 1'b1);
            idx_d   = idx_nx_c;
            rd_en_c = 1'b1;
            rlast_d = (AXILENW'(cnt_q + 1'b1) == len_q);
          end
        end
      end
      ST_WR: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          wr_en_c = (err_q == RESP_OKAY);
          err_d   = w_err_c;
          if (w_beat_last_c || s_axi_wlast) begin
            state_d  = ST_WRESP;
            bvalid_d = 1'b1;
            bresp_d  = w_err_c;
          end else begin
            cnt_d = AXILENW'(cnt_q + 1'b1);
            idx_d = idx_nx_c;
          end
        end
      end
      ST_WRESP: begin
        if (s_axi_bready) begin
          state_d  = ST_IDLE;
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_wr_q <= 1'b0;
      idx_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      inc_q     <= 1'b0;
      err_q     <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      inc_q     <= inc_d;
      err_q     <= err_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // SRAM read port: registered output, forced to zero for errored bursts
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en_c) begin
      rdata_q <= rd_zero_c ? '0 : mem_q[rd_idx_c];
    end
  end

  // SRAM write port with per-byte enables (contents are not reset)
  always_ff @(posedge clk) begin
    if (!rst && wr_en_c) begin
      for (int i = 0; i < NB; i++) begin
        if (s_axi_wstrb[i]) mem_q[idx_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rlast  = rlast_q;
  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;

endmodule
